mux_sel_arbiter: RTL and testbench
==================================

# mux_sel_arbiter

Round-robin arbiter that drives the 2-bit select of the 4:1 channel multiplexer directly upstream of it. It takes four per-channel request lines and grants one channel at a time, holding the select stable for a burst of up to BURST_LEN accepted beats. It then rotates priority to the next requester. A valid/ready handshake with the downstream consumer of the mux output paces the bursts.

## Interface
- BURST_LEN, default 4: number of accepted beats per grant before rearbitration. Legal range 1..256.
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_i  input  4  per-channel request; bit k is channel k, which maps to mux select value k.
- ready_i  input  1  downstream accepts the current mux output sample this cycle.
- sel_o  output  2  mux select; encodes the granted channel.
- gnt_o  output  4  one-hot grant, equal to 1<<sel_o while granted, else 0.
- valid_o  output  1  a grant is active and the mux output is a valid sample.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one channel owns the mux.
- Internal state:
  - last pointer lp (2 bits): the most recently released channel.
  - beat counter bc, width clog2(BURST_LEN)+1.
- Beat: valid_o && ready_i in a cycle.
- Round-robin pick: scan channels lp+1, lp+2, lp+3, lp in order, modulo 4, and select the first one with req_i set.
  - The previously released channel has lowest priority but can still be re-granted.
- IDLE behaviour:
  - If req_i is nonzero, register sel_o = pick, gnt_o = 1<<pick, valid_o = 1, bc = 0, and go to GRANT.
  - Otherwise remain in IDLE.
- GRANT behaviour, with release evaluated every cycle:
  - Release on last beat: a beat occurs and bc == BURST_LEN-1.
  - Release on request drop: req_i[sel_o] == 0. A beat in the same cycle still counts as accepted.
  - No release: on a beat, bc increments. Without a beat, all outputs hold.
  - On release: lp = sel_o, then perform the round-robin pick with the updated lp on the current req_i.
    - If any request is set, load the new grant (sel_o, gnt_o, bc = 0) and stay in GRANT.
    - If no request is set, go to IDLE with gnt_o = 0 and valid_o = 0. sel_o holds its last value.
- sel_o and gnt_o change only at a release or at the IDLE→GRANT transition, never mid-burst.
- ready_i is ignored in IDLE.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Timing
- Reset values (asynchronous, while rst_ni = 0): sel_o = 0, gnt_o = 0, valid_o = 0, state = IDLE, lp = 3, bc = 0.
  - With lp = 3, channel 0 has first priority after reset.
- Reset deassertion is synchronous to clk_i at the integration level. The block takes no action until the first rising edge with rst_ni = 1.
- Grant latency: req_i rising in cycle N while in IDLE gives valid_o/sel_o/gnt_o in cycle N+1.
- Back-to-back grant: release in cycle N with another requester pending gives the new sel_o in cycle N+1 with valid_o held high (zero-bubble handover).
- Release to IDLE: valid_o and gnt_o are low in cycle N+1.
- Burst length: exactly BURST_LEN beats per grant when the owner keeps requesting. Stall cycles (ready_i = 0) extend the grant without counting.
- BURST_LEN = 1: every beat releases, so channels rotate on every accepted beat.
- Simultaneous request drop and last beat: a single release, lp = sel_o.
- Reset mid-burst clears everything immediately. The burst in progress is abandoned and no beat is counted.

## Test plan
- Reset, then req_i = 4'b1111, ready_i = 1, BURST_LEN = 4 -> valid_o rises 1 cycle later. sel_o sequence is 0 for 4 cycles, then 1 for 4, 2 for 4, 3 for 4, then back to 0, with valid_o continuously high.
- req_i = 4'b0100 only, ready_i toggling 1,0,1,0,... -> sel_o = 2 throughout. gnt_o = 4'b0100. The grant re-issues to channel 2 after every 4 accepted beats (8 cycles) without valid_o dropping.
- Grant on channel 1, req_i[1] dropped after 2 beats while req_i[3] = 1 -> next cycle sel_o = 3, gnt_o = 4'b1000, bc restarts. Only 2 beats are counted for channel 1.
- All requests deasserted during GRANT -> next cycle valid_o = 0, gnt_o = 0, sel_o holds its last value. Reasserting req_i = 4'b0001 gives a channel 0 grant one cycle later.
- BURST_LEN = 1, req_i = 4'b1010, ready_i = 1 -> sel_o alternates 1,3,1,3 each cycle.
- rst_ni pulsed low mid-burst on channel 2 -> outputs go to 0 immediately (asynchronously). After release with req_i = 4'b1111, the first grant is channel 0.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sel_arbiter
//  Purpose  : Round-robin arbiter driving the 2-bit select of an upstream 4:1
//             channel mux. A channel keeps the mux for up to BURST_LEN
//             accepted beats (valid_o && ready_i). After that, priority
//             rotates to the next requester.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BURST_LEN  accepted beats per grant before rearbitration (1..256)
//  Ports
//    clk_i      in   1  clock, rising edge
//    rst_ni     in   1  asynchronous active-low reset
//    req_i      in   4  per-channel request, bit k -> mux select k
//    ready_i    in   1  downstream accepts the current mux sample
//    sel_o      out  2  mux select (granted channel), registered
//    gnt_o      out  4  one-hot grant, 1<<sel_o while granted, registered
//    valid_o    out  1  grant active / mux output valid, registered
// ============================================================================
module mux_sel_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_i,
    input  logic       ready_i,
    output logic [1:0] sel_o,
    output logic [3:0] gnt_o,
    output logic       valid_o
);

    localparam int BC_W = $clog2(BURST_LEN) + 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      lp, lp_nxt;
    logic [BC_W-1:0] bc, bc_nxt;
    logic [1:0]      sel_nxt;
    logic [3:0]      gnt_nxt;
    logic            valid_nxt;

    logic            beat;
    logic            release_now;
    logic [2:0]      pick_idle;
    logic [2:0]      pick_rel;

    // Returns {found, index}. Scans last+1, last+2, last+3, last. The loop
    // runs from lowest to highest priority, so the final hit wins.
    function automatic logic [2:0] rr_pick(input logic [1:0] last,
                                           input logic [3:0] req);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign beat        = valid_o & ready_i;
    // A request drop releases even without a beat. A beat in the same
    // cycle is simply accepted. There is no separate bookkeeping for it.
    assign release_now = (beat && (bc == BC_LAST)) || !req_i[sel_o];
    assign pick_idle   = rr_pick(lp, req_i);
    // On release the pointer becomes sel_o, so the pick is based on sel_o.
    assign pick_rel    = rr_pick(sel_o, req_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            lp      <= 2'd3;
            bc      <= '0;
            sel_o   <= 2'd0;
            gnt_o   <= 4'b0000;
            valid_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            lp      <= lp_nxt;
            bc      <= bc_nxt;
            sel_o   <= sel_nxt;
            gnt_o   <= gnt_nxt;
            valid_o <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lp_nxt    = lp;
        bc_nxt    = bc;
        sel_nxt   = sel_o;
        gnt_nxt   = gnt_o;
        valid_nxt = valid_o;

        case (state)
            IDLE: begin
                if (pick_idle[2]) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick_idle[1:0];
                    gnt_nxt   = 4'b0001 << pick_idle[1:0];
                    valid_nxt = 1'b1;
                    bc_nxt    = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    lp_nxt = sel_o;
                    if (pick_rel[2]) begin
                        sel_nxt   = pick_rel[1:0];
                        gnt_nxt   = 4'b0001 << pick_rel[1:0];
                        valid_nxt = 1'b1;
                        bc_nxt    = '0;
                    end else begin
                        // sel_o intentionally holds its last value.
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        valid_nxt = 1'b0;
                        bc_nxt    = '0;
                    end
                end else if (beat) begin
                    bc_nxt = bc + BC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_sel_arbiter
//  Purpose  : Directed self-checking bench for mux_sel_arbiter. One instance
//             uses BURST_LEN=4 and a second uses BURST_LEN=1. Expected
//             values are hand-computed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic       ready_a, ready_b;
    logic [1:0] sel_a, sel_b;
    logic [3:0] gnt_a, gnt_b;
    logic       valid_a, valid_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.BURST_LEN(4)) dut_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req_a),
        .ready_i (ready_a),
        .sel_o   (sel_a),
        .gnt_o   (gnt_a),
        .valid_o (valid_a)
    );

    mux_sel_arbiter #(.BURST_LEN(1)) dut_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req_b),
        .ready_i (ready_b),
        .sel_o   (sel_b),
        .gnt_o   (gnt_b),
        .valid_o (valid_b)
    );

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed {v,sel,gnt}=%b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] pk(input logic v, input logic [1:0] s, input logic [3:0] g);
        return {v, s, g};
    endfunction

    initial begin
        logic [1:0] es;

        // ---- reset ----------------------------------------------------------
        rst_n = 1'b0; req_a = 4'b0000; req_b = 4'b0000;
        ready_a = 1'b0; ready_b = 1'b0;
        #2;
        chk("reset_a", {valid_a, sel_a, gnt_a}, pk(1'b0, 2'd0, 4'b0000));
        chk("reset_b", {valid_b, sel_b, gnt_b}, pk(1'b0, 2'd0, 4'b0000));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", {valid_a, sel_a, gnt_a}, pk(1'b0, 2'd0, 4'b0000));

        // ---- full rotation, BURST_LEN=4 --------------------------------------
        req_a = 4'b1111; ready_a = 1'b1;
        tick();
        for (int k = 0; k <= 16; k++) begin
            es = 2'((k / 4) % 4);
            chk($sformatf("rot_%0d", k), {valid_a, sel_a, gnt_a},
                pk(1'b1, es, 4'b0001 << es));
            if (k != 16) tick();
        end

        // ---- single requester ch2, ready toggling ---------------------------
        req_a = 4'b0100;
        tick();
        chk("ch2_grant", {valid_a, sel_a, gnt_a}, pk(1'b1, 2'd2, 4'b0100));
        for (int i = 0; i < 16; i++) begin
            ready_a = (i % 2 == 0);
            tick();
            chk($sformatf("ch2_hold_%0d", i), {valid_a, sel_a, gnt_a},
                pk(1'b1, 2'd2, 4'b0100));
        end

        // ---- all requests drop -> IDLE, sel holds --------------------------
        req_a = 4'b0000; ready_a = 1'b1;
        tick();
        chk("drop_idle", {valid_a, sel_a, gnt_a}, pk(1'b0, 2'd2, 4'b0000));

        // ---- ch1 grant, drop after 2 beats with ch3 pending -----------------
        req_a = 4'b0010;
        tick();
        chk("ch1_grant", {valid_a, sel_a, gnt_a}, pk(1'b1, 2'd1, 4'b0010));
        req_a = 4'b1010;
        tick();
        chk("ch1_beat1", {valid_a, sel_a, gnt_a}, pk(1'b1, 2'd1, 4'b0010));
        tick();
        chk("ch1_beat2", {valid_a, sel_a, gnt_a}, pk(1'b1, 2'd1, 4'b0010));
        req_a = 4'b1000;
        tick();
        chk("ch3_handover", {valid_a, sel_a, gnt_a}, pk(1'b1, 2'd3, 4'b1000));
        // Counter restarted: ch3 keeps the mux for a full 4 beats.
        req_a = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ch3_burst_%0d", i), {valid_a, sel_a, gnt_a},
                pk(1'b1, 2'd3, 4'b1000));
        end
        tick();
        chk("ch3_to_ch1", {valid_a, sel_a, gnt_a}, pk(1'b1, 2'd1, 4'b0010));

        // ---- drop all, ready ignored in IDLE, then regrant ch0 --------------
        req_a = 4'b0000;
        tick();
        chk("idle_again", {valid_a, sel_a, gnt_a}, pk(1'b0, 2'd1, 4'b0000));
        tick();
        chk("idle_ready_ignored", {valid_a, sel_a, gnt_a}, pk(1'b0, 2'd1, 4'b0000));
        req_a = 4'b0001;
        tick();
        chk("ch0_regrant", {valid_a, sel_a, gnt_a}, pk(1'b1, 2'd0, 4'b0001));

        // ---- stalls extend the grant without counting -----------------------
        req_a = 4'b0011; ready_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("stall_%0d", i), {valid_a, sel_a, gnt_a},
                pk(1'b1, 2'd0, 4'b0001));
        end
        ready_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_stall_%0d", i), {valid_a, sel_a, gnt_a},
                pk(1'b1, 2'd0, 4'b0001));
        end
        tick();
        chk("post_stall_rotate", {valid_a, sel_a, gnt_a}, pk(1'b1, 2'd1, 4'b0010));

        // ---- BURST_LEN=1 alternation ----------------------------------------
        req_b = 4'b1010; ready_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            es = (i % 2 == 0) ? 2'd1 : 2'd3;
            chk($sformatf("bl1_%0d", i), {valid_b, sel_b, gnt_b},
                pk(1'b1, es, 4'b0001 << es));
        end
        req_b = 4'b0000;
        tick();
        chk("bl1_idle", {valid_b, sel_b, gnt_b}, pk(1'b0, 2'd3, 4'b0000));

        // ---- async reset mid-burst on ch2 -----------------------------------
        req_a = 4'b0100;
        tick();
        chk("rst_pre_ch2", {valid_a, sel_a, gnt_a}, pk(1'b1, 2'd2, 4'b0100));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {valid_a, sel_a, gnt_a}, pk(1'b0, 2'd0, 4'b0000));
        tick();
        chk("rst_held", {valid_a, sel_a, gnt_a}, pk(1'b0, 2'd0, 4'b0000));
        rst_n = 1'b1;
        req_a = 4'b1111;
        tick();
        chk("rst_first_ch0", {valid_a, sel_a, gnt_a}, pk(1'b1, 2'd0, 4'b0001));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
